// File: rtl/bbox_tracker_if.sv
// Pixel-stream and published-box signals between the raster source, the
// bounding-box tracker and the rectangle sprite stage.
interface bbox_tracker_if #(
    parameter int CNT_W = 21
);
    logic [10:0]      hcount_in;
    logic [9:0]       vcount_in;
    logic             valid_in;
    logic             mask_in;
    logic             new_frame_in;
    logic [11:0]      xmin_out;
    logic [10:0]      ymin_out;
    logic [11:0]      xmax_out;
    logic [10:0]      ymax_out;
    logic             box_valid_out;
    logic [CNT_W-1:0] pixel_count_out;
    logic             frame_done_out;

    modport master (
        output hcount_in, vcount_in, valid_in, mask_in, new_frame_in,
        input  xmin_out, ymin_out, xmax_out, ymax_out, box_valid_out,
               pixel_count_out, frame_done_out
    );

    modport slave (
        input  hcount_in, vcount_in, valid_in, mask_in, new_frame_in,
        output xmin_out, ymin_out, xmax_out, ymax_out, box_valid_out,
               pixel_count_out, frame_done_out
    );
endinterface

// File: rtl/bbox_tracker.sv
// Per-frame bounding box of masked pixels, published at each frame boundary
// with a minimum-pixel threshold and a miss-hold so the drawn box does not flicker.
module bbox_tracker #(
    parameter int MIN_PIXELS  = 16,
    parameter int HOLD_FRAMES = 4,
    parameter int CNT_W       = 21
) (
    input  logic          clk_in,
    input  logic          rst_in,
    bbox_tracker_if.slave bus
);
    localparam int MISS_W = $clog2(HOLD_FRAMES + 2);
    localparam logic [MISS_W-1:0] MISS_SAT  = MISS_W'(HOLD_FRAMES + 1);
    localparam logic [MISS_W-1:0] MISS_HOLD = MISS_W'(HOLD_FRAMES);
    localparam logic [CNT_W-1:0]  MIN_CNT   = CNT_W'(MIN_PIXELS);
    localparam logic [11:0]       XMIN_INIT = 12'hFFF;
    localparam logic [10:0]       YMIN_INIT = 11'h7FF;

    typedef enum logic {S_WAIT, S_ACCUM} state_t;

    function automatic logic [11:0] umin(input logic [11:0] a, input logic [11:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [11:0] umax(input logic [11:0] a, input logic [11:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [MISS_W-1:0] sat_inc_miss(input logic [MISS_W-1:0] v);
        return (v >= MISS_SAT) ? v : v + 1'b1;
    endfunction

    state_t state, state_nxt;

    logic [11:0]      acc_xmin_p0, acc_xmax_p0, nxt_xmin, nxt_xmax, base_xmin, base_xmax;
    logic [10:0]      acc_ymin_p0, acc_ymax_p0, nxt_ymin, nxt_ymax, base_ymin, base_ymax;
    logic [CNT_W-1:0] acc_cnt_p0, nxt_cnt, base_cnt;

    logic [11:0]       xmin_p1, xmax_p1;
    logic [10:0]       ymin_p1, ymax_p1;
    logic              vld_p1, frame_done_p1;
    logic [CNT_W-1:0]  cnt_p1;
    logic [MISS_W-1:0] miss_cnt, miss_next;

    logic hit, close, accept;

    assign hit       = bus.valid_in & bus.mask_in;
    assign close     = (state == S_ACCUM) && bus.new_frame_in;
    assign accept    = (acc_cnt_p0 >= MIN_CNT);
    assign miss_next = sat_inc_miss(miss_cnt);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= S_WAIT;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == S_WAIT && bus.new_frame_in) state_nxt = S_ACCUM;
    end

    // Stage p0: accumulators reload on any frame pulse; a coincident pixel
    // is the first pixel of the new frame and is folded into the fresh values.
    always_comb begin
        base_xmin = bus.new_frame_in ? XMIN_INIT : acc_xmin_p0;
        base_xmax = bus.new_frame_in ? 12'd0     : acc_xmax_p0;
        base_ymin = bus.new_frame_in ? YMIN_INIT : acc_ymin_p0;
        base_ymax = bus.new_frame_in ? 11'd0     : acc_ymax_p0;
        base_cnt  = bus.new_frame_in ? '0        : acc_cnt_p0;
        nxt_xmin  = base_xmin;
        nxt_xmax  = base_xmax;
        nxt_ymin  = base_ymin;
        nxt_ymax  = base_ymax;
        nxt_cnt   = base_cnt;
        if (hit && (state == S_ACCUM || bus.new_frame_in)) begin
            nxt_xmin = umin(base_xmin, {1'b0, bus.hcount_in});
            nxt_xmax = umax(base_xmax, {1'b0, bus.hcount_in});
            nxt_ymin = 11'(umin({1'b0, base_ymin}, {2'b0, bus.vcount_in}));
            nxt_ymax = 11'(umax({1'b0, base_ymax}, {2'b0, bus.vcount_in}));
            nxt_cnt  = sat_inc_cnt(base_cnt);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            acc_xmin_p0 <= XMIN_INIT;
            acc_xmax_p0 <= '0;
            acc_ymin_p0 <= YMIN_INIT;
            acc_ymax_p0 <= '0;
            acc_cnt_p0  <= '0;
        end else begin
            acc_xmin_p0 <= nxt_xmin;
            acc_xmax_p0 <= nxt_xmax;
            acc_ymin_p0 <= nxt_ymin;
            acc_ymax_p0 <= nxt_ymax;
            acc_cnt_p0  <= nxt_cnt;
        end
    end

    // Stage p1: published box, updated only on a frame close.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            xmin_p1       <= '0;
            xmax_p1       <= '0;
            ymin_p1       <= '0;
            ymax_p1       <= '0;
            vld_p1        <= 1'b0;
            cnt_p1        <= '0;
            frame_done_p1 <= 1'b0;
            miss_cnt      <= '0;
        end else begin
            frame_done_p1 <= close;
            if (close) begin
                cnt_p1 <= acc_cnt_p0;
                if (accept) begin
                    xmin_p1  <= acc_xmin_p0;
                    xmax_p1  <= acc_xmax_p0;
                    ymin_p1  <= acc_ymin_p0;
                    ymax_p1  <= acc_ymax_p0;
                    vld_p1   <= 1'b1;
                    miss_cnt <= '0;
                end else begin
                    miss_cnt <= miss_next;
                    if (miss_next > MISS_HOLD) begin
                        xmin_p1 <= '0;
                        xmax_p1 <= '0;
                        ymin_p1 <= '0;
                        ymax_p1 <= '0;
                        vld_p1  <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.xmin_out        = xmin_p1;
    assign bus.xmax_out        = xmax_p1;
    assign bus.ymin_out        = ymin_p1;
    assign bus.ymax_out        = ymax_p1;
    assign bus.box_valid_out   = vld_p1;
    assign bus.pixel_count_out = cnt_p1;
    assign bus.frame_done_out  = frame_done_p1;
endmodule

// File: tb/tb_bbox_tracker.sv
// Directed bench for bbox_tracker: threshold, miss-hold, frame-boundary pixels,
// pre-frame pixels, async reset mid-frame and invalid-pixel masking.
module tb_bbox_tracker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    bbox_tracker_if #(.CNT_W(21)) bus ();

    bbox_tracker #(.MIN_PIXELS(16), .HOLD_FRAMES(4), .CNT_W(21)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_box(input string tag, input int xmin, input int ymin,
                             input int xmax, input int ymax, input int bv,
                             input int cnt, input int fd);
        chk({tag, ".xmin"}, 32'(bus.xmin_out), xmin);
        chk({tag, ".ymin"}, 32'(bus.ymin_out), ymin);
        chk({tag, ".xmax"}, 32'(bus.xmax_out), xmax);
        chk({tag, ".ymax"}, 32'(bus.ymax_out), ymax);
        chk({tag, ".box_valid"}, 32'(bus.box_valid_out), bv);
        chk({tag, ".pixel_count"}, 32'(bus.pixel_count_out), cnt);
        chk({tag, ".frame_done"}, 32'(bus.frame_done_out), fd);
    endtask

    // Drives one cycle's inputs just after the falling edge.
    task automatic step(input logic nf, input logic vld, input logic msk,
                        input int h, input int v);
        @(negedge clk);
        bus.new_frame_in = nf;
        bus.valid_in     = vld;
        bus.mask_in      = msk;
        bus.hcount_in    = 11'(h);
        bus.vcount_in    = 10'(v);
    endtask

    task automatic pix(input int h, input int v);
        step(1'b0, 1'b1, 1'b1, h, v);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic close_frame();
        step(1'b1, 1'b0, 1'b0, 0, 0);
        idle();
    endtask

    initial begin
        bus.new_frame_in = 1'b0;
        bus.valid_in     = 1'b0;
        bus.mask_in      = 1'b0;
        bus.hcount_in    = '0;
        bus.vcount_in    = '0;
        repeat (3) @(negedge clk);
        check_box("reset", 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Pixels before the first frame pulse are ignored.
        for (int i = 0; i < 5; i++) pix(10, 10);
        close_frame();
        check_box("first_pulse", 0, 0, 0, 0, 0, 0, 0);

        pix(100, 50); pix(300, 50); pix(200, 40); pix(150, 120);
        for (int i = 0; i < 12; i++) pix(200, 80);
        close_frame();
        check_box("s1_close", 100, 40, 300, 120, 1, 16, 1);
        idle();
        check_box("s1_after", 100, 40, 300, 120, 1, 16, 0);

        for (int f = 1; f <= 5; f++) begin
            for (int i = 0; i < 3; i++) pix(250, 60);
            close_frame();
            if (f < 5) check_box($sformatf("s2_hold%0d", f), 100, 40, 300, 120, 1, 3, 1);
            else       check_box("s2_clear", 0, 0, 0, 0, 0, 3, 1);
        end

        // Pixel coinciding with the close pulse belongs to the next frame.
        step(1'b1, 1'b1, 1'b1, 639, 359);
        idle();
        check_box("s3_empty", 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 15; i++) pix(639, 359);
        close_frame();
        check_box("s3_close", 639, 359, 639, 359, 1, 16, 1);

        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b1, 0, 0);
            pix(500 + i, 200);
        end
        close_frame();
        check_box("s6_close", 500, 200, 515, 200, 1, 16, 1);

        for (int i = 0; i < 20; i++) pix(5, 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_box("s5_async", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) pix(5, 5);
        close_frame();
        check_box("s5_first_pulse", 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) pix(700 + i, 300 + i);
        close_frame();
        check_box("s5_close", 700, 300, 715, 315, 1, 16, 1);

        // Back-to-back pulses: two empty frames, box held by miss-hold.
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        check_box("b2b_first", 700, 300, 715, 315, 1, 0, 1);
        idle();
        check_box("b2b_second", 700, 300, 715, 315, 1, 0, 1);
        idle();
        chk("b2b_done_low", 32'(bus.frame_done_out), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
